// File: rtl/key_evt_pkg.sv
// Shared event codes, per-key FSM state encoding and a sizing helper for the key event decoder.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS  = 2'd0,
        EVT_CLICK  = 2'd1,
        EVT_LONG   = 2'd2,
        EVT_REPEAT = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } key_fsm_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Per-key event generator: edge detect, IDLE/DOWN/HELD FSM, hold counter and a 1-deep pending slot.
// REPEAT generation while held is compiled in only when KEY_REPEAT_EN is defined.
module key_event_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pressed,
    input  logic       grant,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       ovf_set
);

    localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             pend_valid_q, pend_valid_d;
    evt_type_e        pend_type_q, pend_type_d;
    logic             evt_fire;
    evt_type_e        evt_new;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = pressed;
        evt_fire = 1'b0;
        evt_new  = EVT_PRESS;

        unique case (state_q)
            ST_IDLE: begin
                if (pressed && !prev_q) begin
                    state_d  = ST_DOWN;
                    cnt_d    = '0;
                    evt_fire = 1'b1;
                    evt_new  = EVT_PRESS;
                end
            end
            ST_DOWN: begin
                // Release is tested first so it beats a same-cycle LONG threshold.
                if (!pressed) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    evt_fire = 1'b1;
                    evt_new  = EVT_CLICK;
                end else if (cnt_q == LONG_LAST) begin
                    state_d  = ST_HELD;
                    cnt_d    = '0;
                    evt_fire = 1'b1;
                    evt_new  = EVT_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    cnt_d    = '0;
                    evt_fire = 1'b1;
                    evt_new  = EVT_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A granted slot is free this cycle, so a new event may reuse it without overflow.
        pend_valid_d = pend_valid_q && !grant;
        pend_type_d  = pend_type_q;
        ovf_set      = 1'b0;
        if (evt_fire) begin
            if (pend_valid_q && !grant) begin
                ovf_set = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_type_d  = evt_new;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= EVT_PRESS;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_type  = pend_type_q;

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced key levels into PRESS/CLICK/LONG/REPEAT events merged into one valid/ready stream.
// Define KEY_REPEAT_EN to enable REPEAT events while a key is held past LONG.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    localparam int KEY_W        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_db,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KEY_W-1:0]  evt_key,
    output logic [1:0]        evt_type,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] ovf,
    input  logic              ovf_clr
);

    logic [N_KEYS-1:0] key_state_q, key_state_d;
    logic [N_KEYS-1:0] ovf_q, ovf_d;
    logic              evt_valid_q, evt_valid_d;
    logic [KEY_W-1:0]  evt_key_q, evt_key_d;
    logic [1:0]        evt_type_q, evt_type_d;
    logic [KEY_W-1:0]  rr_q, rr_d;

    logic [N_KEYS-1:0] pend_valid;
    logic [1:0]        pend_type [N_KEYS];
    logic [N_KEYS-1:0] grant;
    logic [N_KEYS-1:0] ovf_set;
    logic              gnt_found;
    logic [KEY_W-1:0]  gnt_idx;

    assign key_state_d = keys_db ^ {N_KEYS{ACTIVE_LOW}};

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_event_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .pressed    (key_state_q[i]),
            .grant      (grant[i]),
            .pend_valid (pend_valid[i]),
            .pend_type  (pend_type[i]),
            .ovf_set    (ovf_set[i])
        );
    end

    // Round-robin search starting at rr_q; only runs when the output register can take an event.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        grant     = '0;
        for (int off = 0; off < N_KEYS; off++) begin
            idx = (int'(rr_q) + off) % N_KEYS;
            if ((!evt_valid_q || evt_ready) && !gnt_found && pend_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = KEY_W'(idx);
            end
        end
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q && !evt_ready;
        evt_key_d   = evt_key_q;
        evt_type_d  = evt_type_q;
        rr_d        = rr_q;
        if (gnt_found) begin
            evt_valid_d = 1'b1;
            evt_key_d   = gnt_idx;
            evt_type_d  = pend_type[gnt_idx];
            rr_d        = (int'(gnt_idx) == N_KEYS - 1) ? '0 : gnt_idx + KEY_W'(1);
        end
        // Set wins over a same-cycle clear.
        ovf_d = (ovf_q & ~{N_KEYS{ovf_clr}}) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state_q <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= '0;
            rr_q        <= '0;
        end else begin
            key_state_q <= key_state_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_type_q  <= evt_type_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_type  = evt_type_q;
    assign key_state = key_state_q;
    assign ovf       = ovf_q;

endmodule
